// File: rtl/chip_check_pkg.sv
// rtl/chip_check_pkg.sv - shared state type and sizing helper for the chip check sequencer
package chip_check_pkg;

    typedef enum logic [2:0] {
        CC_IDLE,
        CC_LOAD,
        CC_START,
        CC_WAIT,
        CC_CAPTURE,
        CC_DISPLAY
    } cc_state_t;

    // A single-test build still needs a one-bit index port.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/chip_check_sequencer_if.sv
// rtl/chip_check_sequencer_if.sv - sequencer to checker datapath handshake bundle
interface chip_check_sequencer_if #(
    parameter int IDX_W = 2
);
    logic             LD_SW;
    logic             Start_Check;
    logic             LD_RSLT;
    logic [IDX_W-1:0] Test_Idx;
    logic             Check_Done;
    logic             Check_Pass;

    modport master (
        output LD_SW, Start_Check, LD_RSLT, Test_Idx,
        input  Check_Done, Check_Pass
    );

    modport slave (
        input  LD_SW, Start_Check, LD_RSLT, Test_Idx,
        output Check_Done, Check_Pass
    );
endinterface

// File: rtl/chip_check_timer.sv
// rtl/chip_check_timer.sv - clearable WAIT-state cycle counter with expiry flag
module chip_check_timer #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic Clk,
    input  logic Reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMR_W-1:0] count;

    always_ff @(posedge Clk) begin
        if (Reset || clear) begin
            count <= '0;
        end else if (enable && !expire) begin
            count <= count + TMR_W'(1);
        end
    end

    assign expire = (count == TMR_W'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/chip_check_sequencer.sv
// rtl/chip_check_sequencer.sv - runs NUM_TESTS checker passes per Run press and shows a fail mask
module chip_check_sequencer
    import chip_check_pkg::*;
#(
    parameter int NUM_TESTS      = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Run,
    input  logic                 Stop_On_Fail,
    chip_check_sequencer_if.master chk,
    output logic                 DISP_RSLT,
    output logic [NUM_TESTS-1:0] Fail_Mask,
    output logic                 Timeout_Err,
    output logic                 Busy
);
    localparam int IDX_W = idx_width(NUM_TESTS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TESTS - 1);

    cc_state_t        state, state_n;
    logic             run_q, run_rise, stop_q, expire;
    logic [IDX_W-1:0] test_idx;
    logic             start_run, record_done, record_timeout, advance;
    logic             ld_sw, start_check, ld_rslt;

    assign run_rise = Run & ~run_q;

    chip_check_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .Clk    (Clk),
        .Reset  (Reset),
        .clear  (state == CC_START),
        .enable ((state == CC_WAIT) && !chk.Check_Done),
        .expire (expire)
    );

    always_ff @(posedge Clk) begin
        if (Reset) state <= CC_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n        = state;
        ld_sw          = 1'b0;
        start_check    = 1'b0;
        ld_rslt        = 1'b0;
        DISP_RSLT      = 1'b0;
        Busy           = 1'b1;
        start_run      = 1'b0;
        record_done    = 1'b0;
        record_timeout = 1'b0;
        advance        = 1'b0;
        case (state)
            CC_IDLE: begin
                Busy = 1'b0;
                if (run_rise) begin
                    start_run = 1'b1;
                    state_n   = CC_LOAD;
                end
            end
            CC_LOAD: begin
                ld_sw   = 1'b1;
                state_n = CC_START;
            end
            CC_START: begin
                ld_sw       = 1'b1;
                start_check = 1'b1;
                state_n     = CC_WAIT;
            end
            CC_WAIT: begin
                ld_sw   = 1'b1;
                ld_rslt = 1'b1;
                // Done takes priority over a coinciding expiry.
                if (chk.Check_Done) begin
                    record_done = 1'b1;
                    state_n     = CC_CAPTURE;
                end else if (expire) begin
                    record_timeout = 1'b1;
                    state_n        = CC_CAPTURE;
                end
            end
            CC_CAPTURE: begin
                ld_rslt = 1'b1;
                if (test_idx == LAST_IDX || (stop_q && Fail_Mask[test_idx])) begin
                    state_n = CC_DISPLAY;
                end else begin
                    advance = 1'b1;
                    state_n = CC_LOAD;
                end
            end
            CC_DISPLAY: begin
                Busy      = 1'b0;
                DISP_RSLT = 1'b1;
                if (run_rise) begin
                    start_run = 1'b1;
                    state_n   = CC_LOAD;
                end
            end
            default: begin
                Busy    = 1'b0;
                state_n = CC_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            run_q       <= 1'b0;
            stop_q      <= 1'b0;
            test_idx    <= '0;
            Fail_Mask   <= '0;
            Timeout_Err <= 1'b0;
        end else begin
            run_q <= Run;
            if (start_run) begin
                stop_q      <= Stop_On_Fail;
                test_idx    <= '0;
                Fail_Mask   <= '0;
                Timeout_Err <= 1'b0;
            end
            if (record_done) begin
                Fail_Mask[test_idx] <= ~chk.Check_Pass;
            end
            if (record_timeout) begin
                Fail_Mask[test_idx] <= 1'b1;
                Timeout_Err         <= 1'b1;
            end
            if (advance) begin
                test_idx <= test_idx + IDX_W'(1);
            end
        end
    end

    assign chk.LD_SW       = ld_sw;
    assign chk.Start_Check = start_check;
    assign chk.LD_RSLT     = ld_rslt;
    assign chk.Test_Idx    = test_idx;
endmodule

// File: tb/tb_chip_check_sequencer.sv
// tb/tb_chip_check_sequencer.sv - scoreboard bench for chip_check_sequencer
module tb_chip_check_sequencer;
    localparam int NT = 4;
    localparam int TO = 16;
    localparam int IW = 2;

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic          Run = 1'b0;
    logic          Stop_On_Fail = 1'b0;
    logic          DISP_RSLT, Timeout_Err, Busy;
    logic [NT-1:0] Fail_Mask;

    chip_check_sequencer_if #(.IDX_W(IW)) bus ();

    chip_check_sequencer #(.NUM_TESTS(NT), .TIMEOUT_CYCLES(TO)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Run          (Run),
        .Stop_On_Fail (Stop_On_Fail),
        .chk          (bus.master),
        .DISP_RSLT    (DISP_RSLT),
        .Fail_Mask    (Fail_Mask),
        .Timeout_Err  (Timeout_Err),
        .Busy         (Busy)
    );

    always #5 Clk = ~Clk;

    int            errors = 0;
    int            checks = 0;
    int            exp_idx_q[$];
    int            start_cnt = 0;
    int            mon_e;
    int            cfg_delay[NT];
    logic [NT-1:0] cfg_pass;
    int            resp_gen = 0;
    int            resp_idx, resp_my;
    logic [NT-1:0] exp_mask;
    logic          exp_to;
    int            exp_last;

    // Each Start_Check pulse must carry the next index the model queued.
    always @(negedge Clk) begin
        if (bus.Start_Check) begin
            start_cnt++;
            checks++;
            if (exp_idx_q.size() == 0) begin
                errors++;
                $display("FAIL start_unexpected Test_Idx=%0d expected no start", bus.Test_Idx);
            end else begin
                mon_e = exp_idx_q.pop_front();
                if (bus.Test_Idx !== IW'(mon_e)) begin
                    errors++;
                    $display("FAIL start_idx got=%0d exp=%0d", bus.Test_Idx, mon_e);
                end
            end
        end
    end

    // Checker model: answer cfg_delay cycles after Start_Check, unless a reset intervened.
    always begin
        @(negedge Clk);
        if (bus.Start_Check && !Reset) begin
            resp_idx = int'(bus.Test_Idx);
            resp_my  = resp_gen;
            if (cfg_delay[resp_idx] >= 0) begin
                repeat (cfg_delay[resp_idx]) @(posedge Clk);
                if (resp_my == resp_gen) begin
                    #1;
                    bus.Check_Done = 1'b1;
                    bus.Check_Pass = cfg_pass[resp_idx];
                    @(posedge Clk);
                    #1;
                    bus.Check_Done = 1'b0;
                    bus.Check_Pass = 1'b0;
                end
            end
        end
    end

    task automatic set_cfg(input int d, input logic [NT-1:0] p);
        for (int i = 0; i < NT; i++) cfg_delay[i] = d;
        cfg_pass = p;
    endtask

    // Queues expected indices, drives a Run rise, returns at the negedge of the LOAD cycle.
    task automatic launch(input logic stop, input logic hold);
        logic fail, tmo;
        exp_mask = '0;
        exp_to   = 1'b0;
        exp_last = 0;
        for (int i = 0; i < NT; i++) begin
            exp_idx_q.push_back(i);
            exp_last = i;
            tmo  = (cfg_delay[i] < 0) || (cfg_delay[i] > TO);
            fail = tmo || !cfg_pass[i];
            exp_mask[i] = fail;
            if (tmo) exp_to = 1'b1;
            if (stop && fail) break;
        end
        @(negedge Clk);
        Stop_On_Fail = stop;
        Run = 1'b1;
        @(negedge Clk);
        if (!hold) Run = 1'b0;
    endtask

    task automatic wait_display(input string name);
        int n = 0;
        while (!DISP_RSLT && n < 3000) begin
            @(negedge Clk);
            n++;
        end
        checks++;
        if (!DISP_RSLT) begin
            errors++;
            $display("FAIL %s_display_timeout DISP_RSLT=%b exp=1", name, DISP_RSLT);
        end
        checks++;
        if (Fail_Mask !== exp_mask) begin
            errors++;
            $display("FAIL %s_mask got=%b exp=%b", name, Fail_Mask, exp_mask);
        end
        checks++;
        if (Timeout_Err !== exp_to) begin
            errors++;
            $display("FAIL %s_timeout_err got=%b exp=%b", name, Timeout_Err, exp_to);
        end
        checks++;
        if (bus.Test_Idx !== IW'(exp_last) || Busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_final idx=%0d busy=%b exp idx=%0d busy=0", name, bus.Test_Idx, Busy, exp_last);
        end
        checks++;
        if (exp_idx_q.size() != 0) begin
            errors++;
            $display("FAIL %s_missing_starts left=%0d exp=0", name, exp_idx_q.size());
            exp_idx_q.delete();
        end
    endtask

    task automatic check_zero(input string name);
        checks++;
        if ({bus.LD_SW, bus.Start_Check, bus.LD_RSLT, DISP_RSLT, Timeout_Err, Busy} !== 6'b0 ||
            Fail_Mask !== '0 || bus.Test_Idx !== '0) begin
            errors++;
            $display("FAIL %s_outputs ld_sw=%b start=%b ld_rslt=%b disp=%b to=%b busy=%b mask=%b idx=%0d exp all 0",
                     name, bus.LD_SW, bus.Start_Check, bus.LD_RSLT, DISP_RSLT, Timeout_Err, Busy,
                     Fail_Mask, bus.Test_Idx);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (3) @(negedge Clk);
        check_zero("reset");
        Reset = 1'b0;
        @(negedge Clk);
        bus.Check_Done = 1'b1;
        bus.Check_Pass = 1'b0;
        @(negedge Clk);
        bus.Check_Done = 1'b0;
        @(negedge Clk);
        check_zero("stray_done_idle");
    endtask

    task automatic test_all_pass();
        int s0;
        set_cfg(5, 4'b1111);
        s0 = start_cnt;
        launch(1'b0, 1'b0);
        checks++;
        if (bus.LD_SW !== 1'b1 || bus.Start_Check !== 1'b0 || Busy !== 1'b1) begin
            errors++;
            $display("FAIL latency_load ld_sw=%b start=%b busy=%b exp 1 0 1", bus.LD_SW, bus.Start_Check, Busy);
        end
        @(negedge Clk);
        checks++;
        if (bus.Start_Check !== 1'b1) begin
            errors++;
            $display("FAIL latency_start Start_Check=%b exp=1", bus.Start_Check);
        end
        wait_display("all_pass");
        checks++;
        if (start_cnt - s0 != 4) begin
            errors++;
            $display("FAIL all_pass_starts got=%0d exp=4", start_cnt - s0);
        end
    endtask

    task automatic test_fail_mid();
        int s0;
        set_cfg(5, 4'b1011);
        s0 = start_cnt;
        launch(1'b0, 1'b0);
        wait_display("fail_nostop");
        checks++;
        if (start_cnt - s0 != 4 || Fail_Mask !== 4'b0100) begin
            errors++;
            $display("FAIL fail_nostop_starts got=%0d mask=%b exp=4 0100", start_cnt - s0, Fail_Mask);
        end
        s0 = start_cnt;
        launch(1'b1, 1'b0);
        wait_display("fail_stop");
        checks++;
        if (start_cnt - s0 != 3 || bus.Test_Idx !== 2'd2) begin
            errors++;
            $display("FAIL fail_stop_starts got=%0d idx=%0d exp=3 2", start_cnt - s0, bus.Test_Idx);
        end
        Stop_On_Fail = 1'b0;
    endtask

    task automatic test_timeout();
        int n = 0;
        set_cfg(5, 4'b1111);
        cfg_delay[1] = -1;
        launch(1'b0, 1'b0);
        while (!(bus.Start_Check && bus.Test_Idx == 2'd1) && n < 500) begin
            @(negedge Clk);
            n++;
        end
        n = 0;
        while (n < 100) begin
            @(negedge Clk);
            n++;
            if (bus.LD_RSLT && !bus.LD_SW) break;
        end
        // Start cycle + WAIT entry one later + 16 WAIT cycles.
        checks++;
        if (n != 17) begin
            errors++;
            $display("FAIL timeout_capture_cycle got=%0d exp=17", n);
        end
        checks++;
        if (Fail_Mask[1] !== 1'b1 || Timeout_Err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_flags mask1=%b to=%b exp 1 1", Fail_Mask[1], Timeout_Err);
        end
        wait_display("timeout");
    endtask

    task automatic test_expiry_done();
        int s0;
        set_cfg(TO, 4'b1110);
        launch(1'b0, 1'b1);
        wait_display("expiry_done");
        s0 = start_cnt;
        repeat (20) @(negedge Clk);
        checks++;
        if (start_cnt != s0 || DISP_RSLT !== 1'b1) begin
            errors++;
            $display("FAIL held_run_retrigger starts=%0d disp=%b exp=0 1", start_cnt - s0, DISP_RSLT);
        end
        Run = 1'b0;
        @(negedge Clk);
    endtask

    task automatic test_reset_mid();
        int n = 0;
        set_cfg(5, 4'b1111);
        launch(1'b0, 1'b0);
        while (!(bus.LD_SW && bus.LD_RSLT) && n < 50) begin
            @(negedge Clk);
            n++;
        end
        Reset = 1'b1;
        resp_gen++;
        exp_idx_q.delete();
        @(negedge Clk);
        check_zero("reset_in_wait");
        Reset = 1'b0;
        @(negedge Clk);
        launch(1'b0, 1'b0);
        wait_display("after_reset");
        set_cfg(5, 4'b0101);
        launch(1'b0, 1'b0);
        wait_display("pre_reset_disp");
        Reset = 1'b1;
        resp_gen++;
        @(negedge Clk);
        check_zero("reset_in_display");
        Reset = 1'b0;
        @(negedge Clk);
    endtask

    task automatic test_display_rerun();
        set_cfg(5, 4'b0111);
        launch(1'b0, 1'b0);
        wait_display("mask_1000");
        bus.Check_Done = 1'b1;
        bus.Check_Pass = 1'b1;
        @(negedge Clk);
        bus.Check_Done = 1'b0;
        bus.Check_Pass = 1'b0;
        @(negedge Clk);
        checks++;
        if (DISP_RSLT !== 1'b1 || Fail_Mask !== 4'b1000) begin
            errors++;
            $display("FAIL stray_done_display disp=%b mask=%b exp=1 1000", DISP_RSLT, Fail_Mask);
        end
        set_cfg(5, 4'b1111);
        launch(1'b0, 1'b0);
        checks++;
        if (Fail_Mask !== 4'b0000 || bus.LD_SW !== 1'b1 || bus.Test_Idx !== 2'd0) begin
            errors++;
            $display("FAIL rerun_clear mask=%b ld_sw=%b idx=%0d exp=0000 1 0", Fail_Mask, bus.LD_SW, bus.Test_Idx);
        end
        wait_display("rerun");
    endtask

    initial begin
        bus.Check_Done = 1'b0;
        bus.Check_Pass = 1'b0;
        set_cfg(5, 4'b1111);
        test_reset();
        test_all_pass();
        test_fail_mid();
        test_timeout();
        test_expiry_done();
        test_reset_mid();
        test_display_rerun();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end
endmodule
